// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle controller: FSM states,
// instruction classes, CTRL sub-opcodes and jump-select codes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXEC    = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_HALT    = 3'd6,
    S_ILLEGAL = 3'd7
  } state_t;

  localparam logic [1:0] CLS_ALU_R = 2'b00;
  localparam logic [1:0] CLS_ALU_I = 2'b01;
  localparam logic [1:0] CLS_MEM   = 2'b10;
  localparam logic [1:0] CLS_CTRL  = 2'b11;

  localparam logic [1:0] CT_BEQ  = 2'b00;
  localparam logic [1:0] CT_J    = 2'b01;
  localparam logic [1:0] CT_JR   = 2'b10;
  localparam logic [1:0] CT_HALT = 2'b11;

  localparam logic [1:0] JMP_NONE = 2'b00;
  localparam logic [1:0] JMP_J    = 2'b01;
  localparam logic [1:0] JMP_JR   = 2'b10;

  localparam int unsigned ALU_ADD = 0;

  function automatic logic is_halt(input logic [1:0] cls, input logic [1:0] sub);
    return (cls == CLS_CTRL) && (sub == CT_HALT);
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Memory-side handshake of the multicycle controller: request/write qualifier
// out, acknowledge and raw opcode back.
interface multicycle_controller_if #(
  parameter int OP_W = 6
);
  logic            mem_req;
  logic            mem_write;
  logic            mem_ack;
  logic [OP_W-1:0] op;

  modport master (output mem_req, output mem_write, input mem_ack, input op);
  modport slave  (input mem_req, input mem_write, output mem_ack, output op);
endinterface

// File: rtl/ctrl_outdec.sv
// Combinational output decode: state + registered opcode give every datapath
// enable; mem_ack (FETCH) and branch_flag (BEQ in EXEC) are the only live inputs.
module ctrl_outdec
  import ctrl_pkg::*;
#(
  parameter int OP_W     = 6,
  parameter int FUNCT_W  = 4,
  parameter int ALUCTL_W = 4,
  parameter int ACC_W    = 3
) (
  input  state_t              state,
  input  logic [OP_W-1:0]     op_q,
  input  logic                mem_ack,
  input  logic                branch_flag,
  output logic                mem_req,
  output logic                mem_write,
  output logic                ir_load,
  output logic                pc_write,
  output logic                pc_src,
  output logic [1:0]          jump,
  output logic                alu_src,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic [ALUCTL_W-1:0] alu_control,
  output logic [ACC_W-1:0]    acc_control,
  output logic                halted
);

  logic [1:0] cls;
  logic [1:0] sub;

  assign cls = op_q[5:4];
  assign sub = op_q[1:0];

  always_comb begin
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    ir_load     = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    jump        = JMP_NONE;
    alu_src     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    alu_control = ALUCTL_W'(ALU_ADD);
    acc_control = '0;
    halted      = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_load  = mem_ack;
        pc_write = mem_ack;
      end
      S_EXEC: begin
        case (cls)
          CLS_ALU_R, CLS_ALU_I: begin
            alu_src     = (cls == CLS_ALU_I);
            alu_control = ALUCTL_W'(op_q[FUNCT_W-1:0]);
            acc_control = op_q[ACC_W-1:0];
          end
          CLS_MEM: alu_src = 1'b1;
          default: begin
            case (sub)
              CT_BEQ: begin
                pc_write = branch_flag;
                pc_src   = 1'b1;
              end
              CT_J: begin
                pc_write = 1'b1;
                jump     = JMP_J;
              end
              CT_JR: begin
                pc_write = 1'b1;
                jump     = JMP_JR;
              end
              default: ;
            endcase
          end
        endcase
      end
      S_MEM: begin
        mem_req   = 1'b1;
        mem_write = op_q[0];
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls == CLS_MEM);
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB FSM, opcode
// register, and optional perf counters enabled by CTRL_PERF_CNT_EN.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int OP_W     = 6,
  parameter int FUNCT_W  = 4,
  parameter int ALUCTL_W = 4,
  parameter int ACC_W    = 3,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  input  logic                branch_flag,
  multicycle_controller_if.master mem,
  output logic                ir_load,
  output logic                pc_write,
  output logic                pc_src,
  output logic [1:0]          jump,
  output logic                alu_src,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic [ALUCTL_W-1:0] alu_control,
  output logic [ACC_W-1:0]    acc_control,
  output logic [2:0]          state,
  output logic                halted,
  output logic [CNT_W-1:0]    cycle_cnt,
  output logic [CNT_W-1:0]    instr_cnt
);

  state_t          state_q;
  state_t          state_d;
  logic [OP_W-1:0] op_q;
  logic [1:0]      cls;
  logic [1:0]      sub;
  logic            mem_req_w;
  logic            mem_write_w;

  assign cls   = op_q[5:4];
  assign sub   = op_q[1:0];
  assign state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (ir_load) op_q <= mem.op;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (instr_valid) state_d = S_FETCH;
      S_FETCH:  if (mem.mem_ack) state_d = S_DECODE;
      S_DECODE: state_d = is_halt(cls, sub) ? S_HALT : S_EXEC;
      S_EXEC: begin
        case (cls)
          CLS_ALU_R, CLS_ALU_I: state_d = S_WB;
          CLS_MEM:              state_d = S_MEM;
          default:              state_d = S_FETCH;
        endcase
      end
      S_MEM:    if (mem.mem_ack) state_d = op_q[0] ? S_FETCH : S_WB;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  ctrl_outdec #(
    .OP_W     (OP_W),
    .FUNCT_W  (FUNCT_W),
    .ALUCTL_W (ALUCTL_W),
    .ACC_W    (ACC_W)
  ) u_outdec (
    .state       (state_q),
    .op_q        (op_q),
    .mem_ack     (mem.mem_ack),
    .branch_flag (branch_flag),
    .mem_req     (mem_req_w),
    .mem_write   (mem_write_w),
    .ir_load     (ir_load),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .jump        (jump),
    .alu_src     (alu_src),
    .mem_to_reg  (mem_to_reg),
    .reg_write   (reg_write),
    .alu_control (alu_control),
    .acc_control (acc_control),
    .halted      (halted)
  );

  assign mem.mem_req   = mem_req_w;
  assign mem.mem_write = mem_write_w;

`ifdef CTRL_PERF_CNT_EN
  // An instruction retires when the FSM leaves its final state for FETCH, or on HALT entry.
  logic             retire;
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instr_q;

  assign retire = ((state_d == S_FETCH) &&
                   (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB)) ||
                  ((state_d == S_HALT) && (state_q == S_DECODE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      if (state_q != S_IDLE && state_q != S_HALT) cycle_q <= cycle_q + CNT_W'(1);
      if (retire) instr_q <= instr_q + CNT_W'(1);
    end
  end

  assign cycle_cnt = cycle_q;
  assign instr_cnt = instr_q;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expected output vectors
// are queued by the stimulus and checked by a negedge scoreboard monitor.
module tb_multicycle_controller;

  localparam logic [2:0] ST_I = 3'd0, ST_F = 3'd1, ST_D = 3'd2, ST_E = 3'd3,
                         ST_M = 3'd4, ST_W = 3'd5, ST_H = 3'd6;
  localparam logic [8:0] Z   = 9'h000;
  localparam logic [8:0] MRQ = 9'h100, MWR = 9'h080, IRL = 9'h040, PCW = 9'h020,
                         PCS = 9'h010, ASR = 9'h008, M2R = 9'h004, RW  = 9'h002,
                         HLT = 9'h001;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        branch_flag;
  logic        ir_load, pc_write, pc_src, alu_src, mem_to_reg, reg_write, halted;
  logic [1:0]  jump;
  logic [3:0]  alu_control;
  logic [2:0]  acc_control;
  logic [2:0]  state;
  logic [31:0] cycle_cnt, instr_cnt;

  multicycle_controller_if #(.OP_W(6)) mif ();

  multicycle_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .branch_flag (branch_flag),
    .mem         (mif),
    .ir_load     (ir_load),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .jump        (jump),
    .alu_src     (alu_src),
    .mem_to_reg  (mem_to_reg),
    .reg_write   (reg_write),
    .alu_control (alu_control),
    .acc_control (acc_control),
    .state       (state),
    .halted      (halted),
    .cycle_cnt   (cycle_cnt),
    .instr_cnt   (instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [20:0] obs;
  assign obs = {state, mif.mem_req, mif.mem_write, ir_load, pc_write, pc_src, jump,
                alu_src, mem_to_reg, reg_write, halted, alu_control, acc_control};

  string       tag_q[$];
  logic [20:0] exp_q[$];
  logic [63:0] cnt_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          exp_cyc = 0;

  function automatic logic [20:0] ev(input logic [2:0] st, input logic [8:0] f,
                                     input logic [1:0] j, input logic [3:0] a,
                                     input logic [2:0] c);
    return {st, f[8], f[7], f[6], f[5], f[4], j, f[3], f[2], f[1], f[0], a, c};
  endfunction

  // One clock of stimulus; the expected outputs for this cycle go to the scoreboard.
  task automatic cyc(input string tag, input logic iv, input logic ack, input logic bf,
                     input logic [5:0] opv, input logic [20:0] e);
    instr_valid = iv;
    mif.mem_ack = ack;
    branch_flag = bf;
    mif.op      = opv;
    tag_q.push_back(tag);
    exp_q.push_back(e);
    if (rst_n && e[20:18] != ST_I && e[20:18] != ST_H) exp_cyc++;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    string       t;
    logic [20:0] e;
    logic [63:0] c;
    if (exp_q.size() != 0) begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", t, obs, e);
      end
    end
    if (cnt_q.size() != 0) begin
      c = cnt_q.pop_front();
      n_cmp++;
      assert ({cycle_cnt, instr_cnt} === c) else begin
        n_err++;
        $error("FAIL counters: observed cyc=%0d ins=%0d expected cyc=%0d ins=%0d",
               cycle_cnt, instr_cnt, c[63:32], c[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    branch_flag = 1'b0;
    mif.mem_ack = 1'b0;
    mif.op      = 6'd0;
    @(posedge clk);
    #1;
    cyc("rst_state",    1'b0, 1'b0, 1'b0, 6'd0, ev(ST_I, Z, 2'b00, 4'h0, 3'h0));
    rst_n = 1'b1;
    cyc("idle_nostart", 1'b0, 1'b1, 1'b0, 6'd0, ev(ST_I, Z, 2'b00, 4'h0, 3'h0));
    cyc("idle_start",   1'b1, 1'b0, 1'b0, 6'd0, ev(ST_I, Z, 2'b00, 4'h0, 3'h0));
    cyc("fetch_wait",   1'b0, 1'b0, 1'b0, 6'd0, ev(ST_F, MRQ, 2'b00, 4'h0, 3'h0));

    // Asynchronous reset mid-FETCH: checked before any further clock edge.
    rst_n = 1'b0;
    exp_cyc = 0;
    cyc("rst_mid_fetch", 1'b1, 1'b1, 1'b0, 6'd0, ev(ST_I, Z, 2'b00, 4'h0, 3'h0));
    cyc("rst_late_ack",  1'b1, 1'b1, 1'b0, 6'd0, ev(ST_I, Z, 2'b00, 4'h0, 3'h0));
    rst_n = 1'b1;
    cyc("idle_restart",  1'b1, 1'b0, 1'b0, 6'd0, ev(ST_I, Z, 2'b00, 4'h0, 3'h0));

    // ALU-R with stray acks and junk on op after the fetch.
    cyc("alur_fetch",  1'b0, 1'b1, 1'b0, 6'b000101, ev(ST_F, MRQ|IRL|PCW, 2'b00, 4'h0, 3'h0));
    cyc("alur_decode", 1'b0, 1'b1, 1'b0, 6'b111111, ev(ST_D, Z, 2'b00, 4'h0, 3'h0));
    cyc("alur_exec",   1'b0, 1'b1, 1'b1, 6'b111111, ev(ST_E, Z, 2'b00, 4'h5, 3'h5));
    cyc("alur_wb",     1'b0, 1'b1, 1'b0, 6'b111111, ev(ST_W, RW, 2'b00, 4'h0, 3'h0));

    // Load with two wait cycles in MEM.
    cyc("ld_fetch",   1'b0, 1'b1, 1'b0, 6'b100000, ev(ST_F, MRQ|IRL|PCW, 2'b00, 4'h0, 3'h0));
    cyc("ld_decode",  1'b0, 1'b0, 1'b0, 6'd0, ev(ST_D, Z, 2'b00, 4'h0, 3'h0));
    cyc("ld_exec",    1'b0, 1'b0, 1'b0, 6'd0, ev(ST_E, ASR, 2'b00, 4'h0, 3'h0));
    cyc("ld_mem_w1",  1'b0, 1'b0, 1'b0, 6'd0, ev(ST_M, MRQ, 2'b00, 4'h0, 3'h0));
    cyc("ld_mem_w2",  1'b0, 1'b0, 1'b0, 6'd0, ev(ST_M, MRQ, 2'b00, 4'h0, 3'h0));
    cyc("ld_mem_ack", 1'b0, 1'b1, 1'b0, 6'd0, ev(ST_M, MRQ, 2'b00, 4'h0, 3'h0));
    cyc("ld_wb",      1'b0, 1'b0, 1'b0, 6'd0, ev(ST_W, RW|M2R, 2'b00, 4'h0, 3'h0));

    // Store, zero-wait.
    cyc("st_fetch",  1'b0, 1'b1, 1'b0, 6'b100001, ev(ST_F, MRQ|IRL|PCW, 2'b00, 4'h0, 3'h0));
    cyc("st_decode", 1'b0, 1'b0, 1'b0, 6'd0, ev(ST_D, Z, 2'b00, 4'h0, 3'h0));
    cyc("st_exec",   1'b0, 1'b0, 1'b0, 6'd0, ev(ST_E, ASR, 2'b00, 4'h0, 3'h0));
    cyc("st_mem",    1'b0, 1'b1, 1'b0, 6'd0, ev(ST_M, MRQ|MWR, 2'b00, 4'h0, 3'h0));

    // ALU-I.
    cyc("alui_fetch",  1'b0, 1'b1, 1'b0, 6'b010011, ev(ST_F, MRQ|IRL|PCW, 2'b00, 4'h0, 3'h0));
    cyc("alui_decode", 1'b0, 1'b0, 1'b0, 6'd0, ev(ST_D, Z, 2'b00, 4'h0, 3'h0));
    cyc("alui_exec",   1'b0, 1'b0, 1'b0, 6'd0, ev(ST_E, ASR, 2'b00, 4'h3, 3'h3));
    cyc("alui_wb",     1'b0, 1'b0, 1'b0, 6'd0, ev(ST_W, RW, 2'b00, 4'h0, 3'h0));

    // BEQ taken, then not taken.
    cyc("beq1_fetch",  1'b0, 1'b1, 1'b0, 6'b110000, ev(ST_F, MRQ|IRL|PCW, 2'b00, 4'h0, 3'h0));
    cyc("beq1_decode", 1'b0, 1'b0, 1'b1, 6'd0, ev(ST_D, Z, 2'b00, 4'h0, 3'h0));
    cyc("beq1_exec",   1'b0, 1'b0, 1'b1, 6'd0, ev(ST_E, PCW|PCS, 2'b00, 4'h0, 3'h0));
    cyc("beq0_fetch",  1'b0, 1'b1, 1'b0, 6'b110000, ev(ST_F, MRQ|IRL|PCW, 2'b00, 4'h0, 3'h0));
    cyc("beq0_decode", 1'b0, 1'b0, 1'b0, 6'd0, ev(ST_D, Z, 2'b00, 4'h0, 3'h0));
    cyc("beq0_exec",   1'b0, 1'b0, 1'b0, 6'd0, ev(ST_E, PCS, 2'b00, 4'h0, 3'h0));

    // J with one fetch wait, then JR.
    cyc("j_fetch_wait", 1'b0, 1'b0, 1'b0, 6'b110001, ev(ST_F, MRQ, 2'b00, 4'h0, 3'h0));
    cyc("j_fetch",      1'b0, 1'b1, 1'b0, 6'b110001, ev(ST_F, MRQ|IRL|PCW, 2'b00, 4'h0, 3'h0));
    cyc("j_decode",     1'b0, 1'b0, 1'b0, 6'd0, ev(ST_D, Z, 2'b00, 4'h0, 3'h0));
    cyc("j_exec",       1'b0, 1'b0, 1'b0, 6'd0, ev(ST_E, PCW, 2'b01, 4'h0, 3'h0));
    cyc("jr_fetch",     1'b0, 1'b1, 1'b0, 6'b110010, ev(ST_F, MRQ|IRL|PCW, 2'b00, 4'h0, 3'h0));
    cyc("jr_decode",    1'b0, 1'b0, 1'b0, 6'd0, ev(ST_D, Z, 2'b00, 4'h0, 3'h0));
    cyc("jr_exec",      1'b0, 1'b0, 1'b0, 6'd0, ev(ST_E, PCW, 2'b10, 4'h0, 3'h0));

    // HALT is sticky against instr_valid, mem_ack and branch_flag.
    cyc("halt_fetch",  1'b0, 1'b1, 1'b0, 6'b110011, ev(ST_F, MRQ|IRL|PCW, 2'b00, 4'h0, 3'h0));
    cyc("halt_decode", 1'b0, 1'b0, 1'b0, 6'd0, ev(ST_D, Z, 2'b00, 4'h0, 3'h0));
    cyc("halt_1",      1'b1, 1'b1, 1'b0, 6'd0, ev(ST_H, HLT, 2'b00, 4'h0, 3'h0));
    cyc("halt_2",      1'b1, 1'b0, 1'b1, 6'b000101, ev(ST_H, HLT, 2'b00, 4'h0, 3'h0));
`ifdef CTRL_PERF_CNT_EN
    cnt_q.push_back({32'(exp_cyc), 32'd9});
`else
    cnt_q.push_back(64'd0);
`endif
    cyc("halt_3",      1'b0, 1'b1, 1'b1, 6'd0, ev(ST_H, HLT, 2'b00, 4'h0, 3'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
